// File: rtl/frame_scheduler.sv
// Sender-side frame pacing: walks ROWS x COLS byte slots, strobes payload reads,
// stalls only on payload columns when the client FIFO runs dry.
module frame_scheduler #(
  parameter int ROWS        = 4,
  parameter int COLS        = 1041,
  parameter int OH_COLS     = 16,
  parameter int LVL_W       = 12,
  parameter int FILL_THRESH = 1024,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int COL_W      = $clog2(COLS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_arq_en_cfg,
  input  logic             i_fifo_empty,
  input  logic [LVL_W-1:0] i_fifo_level,
  output logic             o_pyld_rd,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [COL_W-1:0] o_col_cnt,
  output logic             o_arq_en,
  output logic             o_frame_start,
  output logic             o_busy,
  output logic [15:0]      o_underrun_cnt
);

  // state | meaning
  // IDLE  | parked on a payload slot, waiting for enable and FIFO fill
  // RUN   | walking frame slots; stalls in place on payload underrun
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] PARK_COL = COL_W'(OH_COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [LVL_W-1:0] THRESH   = LVL_W'(FILL_THRESH);

  state_t           state;
  logic [ROW_W-1:0] r;
  logic [COL_W-1:0] c;
  logic             pyld_slot;
  logic             stall;
  logic             last_col;
  logic             frame_end;

  assign pyld_slot = (c >= PARK_COL) && (c < LAST_COL);
  assign stall     = (state == RUN) && pyld_slot && i_fifo_empty;
  assign last_col  = (c == LAST_COL);
  assign frame_end = last_col && (r == LAST_ROW);
  // FIFO returns data one cycle later, lining up with the registered position
  assign o_pyld_rd = (state == RUN) && pyld_slot && !i_fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      r              <= '0;
      c              <= '0;
      o_row_cnt      <= '0;
      o_col_cnt      <= PARK_COL;
      o_arq_en       <= 1'b0;
      o_frame_start  <= 1'b0;
      o_busy         <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      o_frame_start <= 1'b0;
      o_row_cnt     <= '0;
      o_col_cnt     <= PARK_COL;
      case (state)
        IDLE: begin
          if (i_en && (i_fifo_level >= THRESH)) begin
            state    <= RUN;
            o_busy   <= 1'b1;
            r        <= '0;
            c        <= '0;
            o_arq_en <= i_arq_en_cfg;
          end
        end
        RUN: begin
          o_row_cnt     <= r;
          o_col_cnt     <= c;
          // column 0 is overhead and can never be a stall repeat
          o_frame_start <= (r == '0) && (c == '0);
          if (stall) begin
            if (o_underrun_cnt != 16'hFFFF)
              o_underrun_cnt <= o_underrun_cnt + 16'd1;
          end else if (frame_end) begin
            r <= '0;
            c <= '0;
            if (i_en) begin
              o_arq_en <= i_arq_en_cfg;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else if (last_col) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: slot-index reference model feeds queues,
// independent monitors compare every output cycle.
module tb_frame_scheduler;
  localparam int ROWS  = 4;
  localparam int COLS  = 1041;
  localparam int OH    = 16;
  localparam int FILL  = 1024;
  localparam int FRAME = ROWS * COLS;
  localparam int READS = ROWS * (COLS - OH - 1);

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_en = 1'b0;
  logic        i_arq_en_cfg = 1'b0;
  logic        i_fifo_empty = 1'b0;
  logic [11:0] i_fifo_level = '0;
  logic        o_pyld_rd;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_arq_en;
  logic        o_frame_start;
  logic        o_busy;
  logic [15:0] o_underrun_cnt;

  frame_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_arq_en_cfg(i_arq_en_cfg),
    .i_fifo_empty(i_fifo_empty), .i_fifo_level(i_fifo_level),
    .o_pyld_rd(o_pyld_rd), .o_row_cnt(o_row_cnt), .o_col_cnt(o_col_cnt),
    .o_arq_en(o_arq_en), .o_frame_start(o_frame_start), .o_busy(o_busy),
    .o_underrun_cnt(o_underrun_cnt)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {int row; int col; int fs; int arq; int busy; int ucnt;} exp_t;
  typedef struct {int cycles; int reads;} meas_t;
  exp_t  out_q[$];
  int    rd_q[$];
  meas_t meas_q[$];

  // Reference model: a running flag plus a linear slot index over the frame.
  int   m_run, m_k, m_arq, m_ucnt, m_col, m_pay, m_rd;
  exp_t m_e;
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      m_run = 0; m_k = 0; m_arq = 0; m_ucnt = 0;
    end else begin
      if (m_run == 0) begin
        m_rd = 0; m_e.row = 0; m_e.col = OH; m_e.fs = 0;
        if (i_en && int'(i_fifo_level) >= FILL) begin
          m_run = 1; m_k = 0; m_arq = int'(i_arq_en_cfg);
        end
      end else begin
        m_col = m_k % COLS;
        m_pay = int'(m_col >= OH && m_col <= COLS - 2);
        m_e.row = m_k / COLS; m_e.col = m_col; m_e.fs = int'(m_k == 0);
        m_rd = int'(m_pay == 1 && !i_fifo_empty);
        if (m_pay == 1 && i_fifo_empty) begin
          if (m_ucnt < 65535) m_ucnt++;
        end else if (m_k == FRAME - 1) begin
          m_k = 0;
          if (i_en) m_arq = int'(i_arq_en_cfg);
          else m_run = 0;
        end else begin
          m_k++;
        end
      end
      m_e.arq = m_arq; m_e.busy = m_run; m_e.ucnt = m_ucnt;
      out_q.push_back(m_e);
      rd_q.push_back(m_rd);
    end
  end

  int   mon_rd;
  exp_t mon_e;
  initial forever begin
    @(negedge i_clk); #1;
    if (rd_q.size() > 0) begin
      mon_rd = rd_q.pop_front();
      check("pyld_rd", int'(o_pyld_rd), mon_rd);
    end
  end

  initial forever begin
    @(posedge i_clk); #1;
    if (out_q.size() > 0) begin
      mon_e = out_q.pop_front();
      check("row_cnt", int'(o_row_cnt), mon_e.row);
      check("col_cnt", int'(o_col_cnt), mon_e.col);
      check("frame_start", int'(o_frame_start), mon_e.fs);
      check("arq_en", int'(o_arq_en), mon_e.arq);
      check("busy", int'(o_busy), mon_e.busy);
      check("underrun_cnt", int'(o_underrun_cnt), mon_e.ucnt);
    end
  end

  // Frame length and read count between consecutive frame_start pulses
  int mc_cycles = 0, mc_reads = 0, have_prev = 0;
  initial forever begin
    @(posedge i_clk); #1;
    mc_cycles++;
    if (!o_busy) have_prev = 0;
    else if (o_frame_start) begin
      if (have_prev != 0) meas_q.push_back('{mc_cycles, mc_reads});
      have_prev = 1; mc_cycles = 0; mc_reads = 0;
    end
  end
  initial forever begin
    @(negedge i_clk); #2;
    if (o_pyld_rd === 1'b1) mc_reads++;
  end

  task automatic wait_out(input int row, input int col, input int budget, input string nm);
    int n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (!(int'(o_row_cnt) == row && int'(o_col_cnt) == col) && n < budget);
    check(nm, int'(int'(o_row_cnt) == row && int'(o_col_cnt) == col), 1);
  endtask

  task automatic wait_fs(input int budget, input string nm);
    int n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (o_frame_start !== 1'b1 && n < budget);
    check(nm, int'(o_frame_start === 1'b1), 1);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_row"}, int'(o_row_cnt), 0);
    check({nm, "_col"}, int'(o_col_cnt), OH);
    check({nm, "_rd"}, int'(o_pyld_rd), 0);
    check({nm, "_arq"}, int'(o_arq_en), 0);
    check({nm, "_fs"}, int'(o_frame_start), 0);
    check({nm, "_busy"}, int'(o_busy), 0);
    check({nm, "_ucnt"}, int'(o_underrun_cnt), 0);
  endtask

  meas_t mm;
  int    n100;
  initial begin
    #2 i_rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1; i_en = 1'b0; i_fifo_level = 12'd2000;

    // idle parking with enable low
    for (int i = 0; i < 50; i++) begin
      @(posedge i_clk); #1;
      check("park_row", int'(o_row_cnt), 0);
      check("park_col", int'(o_col_cnt), OH);
      check("park_busy", int'(o_busy), 0);
    end

    // enabled but FIFO below threshold
    #1 i_en = 1'b1; i_arq_en_cfg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_fifo_level = 12'(1023 - $urandom_range(0, 1023) % 2 * $urandom_range(0, 500));
      @(posedge i_clk); #1;
      check("below_thresh_busy", int'(o_busy), 0);
      #1;
    end
    i_fifo_level = 12'd1024;

    wait_fs(10, "start_a");
    wait_fs(FRAME + 10, "start_b");
    wait_fs(FRAME + 10, "start_c");

    // frame C: empty over row 1 overhead columns must not stall
    wait_out(0, 1040, FRAME, "pos_r0c1040");
    #1 i_fifo_empty = 1'b1;
    repeat (16) @(posedge i_clk);
    #2 i_fifo_empty = 1'b0;
    repeat (4) @(posedge i_clk);
    #1 check("no_stall_on_oh", int'(o_underrun_cnt), 0);

    // frame C: three-cycle underrun at row 2 column 100
    wait_out(2, 99, FRAME, "pos_r2c99");
    #1 i_fifo_empty = 1'b1;
    n100 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      if (int'(o_col_cnt) == 100) n100++;
      if (i == 2) begin #1 i_fifo_empty = 1'b0; end
    end
    check("col100_repeats", n100, 4);
    check("underrun_3", int'(o_underrun_cnt), 3);

    wait_fs(FRAME + 20, "start_d");
    @(negedge i_clk);
    check("meas_count", int'(meas_q.size() >= 3), 1);
    if (meas_q.size() >= 3) begin
      mm = meas_q.pop_front(); check("len_a", mm.cycles, FRAME); check("reads_a", mm.reads, READS);
      mm = meas_q.pop_front(); check("len_b", mm.cycles, FRAME); check("reads_b", mm.reads, READS);
      mm = meas_q.pop_front(); check("len_c", mm.cycles, FRAME + 3); check("reads_c", mm.reads, READS);
    end
    meas_q.delete();

    // frame D: random underruns, config and level noise
    for (int i = 0; i < 10000; i++) begin
      @(posedge i_clk); #1;
      if (o_row_cnt == 2'd3 && o_col_cnt >= 11'd1000) break;
      #1;
      i_fifo_empty = ($urandom_range(0, 7) == 0);
      i_arq_en_cfg = 1'($urandom_range(0, 1));
      i_fifo_level = 12'($urandom_range(0, 4095));
    end
    #1 i_fifo_empty = 1'b0; i_arq_en_cfg = 1'b0;

    // frame E: stop request and ARQ toggle mid-frame
    wait_fs(200, "start_e");
    check("arq_e_start", int'(o_arq_en), 0);
    wait_out(1, 500, FRAME, "pos_r1c500");
    #1 i_en = 1'b0; i_arq_en_cfg = 1'b1;
    repeat (5) @(posedge i_clk);
    #1 check("arq_hold_mid", int'(o_arq_en), 0);
    for (int i = 0; i < FRAME; i++) begin
      if (!o_busy) break;
      @(posedge i_clk); #1;
    end
    check("stop_idle", int'(o_busy), 0);
    check("stop_last_row", int'(o_row_cnt), 3);
    check("stop_last_col", int'(o_col_cnt), COLS - 1);
    @(posedge i_clk); #1;
    check("stop_park_col", int'(o_col_cnt), OH);
    check("stop_arq", int'(o_arq_en), 0);

    #1 i_en = 1'b1; i_fifo_level = 12'd1100;
    wait_fs(10, "restart");
    check("arq_next_frame", int'(o_arq_en), 1);

    // asynchronous reset mid-frame
    wait_out(2, 700, FRAME, "pos_r2c700");
    #2 i_rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    out_q.delete(); rd_q.delete(); meas_q.delete();
    repeat (3) @(posedge i_clk);
    #2 i_fifo_level = 12'd500; i_en = 1'b1; i_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk); #1;
      check("post_rst_wait", int'(o_busy), 0);
    end
    #1 i_fifo_level = 12'd1024;
    wait_fs(10, "post_rst_start");
    check("post_rst_row", int'(o_row_cnt), 0);
    check("post_rst_col", int'(o_col_cnt), 0);
    repeat (40) @(posedge i_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
